// File: rtl/serial_fa_pkg.sv
// Shared types and constants for the bit-serial adder controller and its FA cell.
package serial_fa_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned FA_A = 2;
  localparam int unsigned FA_B = 1;
  localparam int unsigned FA_C = 0;

endpackage

// File: rtl/decoder_fa.sv
// Full adder built from a 3-to-8 minterm decoder; in[2]=a, in[1]=b, in[0]=carry-in.
module decoder_fa (
  input  logic [2:0] in,
  output logic       sum,
  output logic       carry
);

  logic [7:0] w_dec;

  always_comb begin
    w_dec = 8'd0;
    w_dec[in] = 1'b1;
  end

  // Odd-parity minterms give the sum, two-or-more-ones minterms give the carry.
  assign sum   = w_dec[1] | w_dec[2] | w_dec[4] | w_dec[7];
  assign carry = w_dec[3] | w_dec[5] | w_dec[6] | w_dec[7];

endmodule

// File: rtl/serial_fa_ctrl.sv
// Bit-serial adder: one shared decoder_fa cell stepped WIDTH times, LSB first.
// Optional SERIAL_FA_SUB_EN adds a 'sub' input selecting a-b (cout=1 means no borrow).
module serial_fa_ctrl
  import serial_fa_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_FA_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  state_e           r_state;
  state_e           w_next;
  logic             w_load;
  logic             w_step;
  logic             w_last;

  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_busy;
  logic             r_done;

  logic [2:0]       w_fa_in;
  logic             w_fa_sum;
  logic             w_fa_carry;
  logic [WIDTH-1:0] w_b_load;
  logic             w_c_load;

`ifdef SERIAL_FA_SUB_EN
  // Subtraction as a + ~b + 1; cin is ignored when sub is set.
  assign w_b_load = sub ? ~b : b;
  assign w_c_load = sub ? 1'b1 : cin;
`else
  assign w_b_load = b;
  assign w_c_load = cin;
`endif

  always_comb begin
    w_fa_in       = 3'd0;
    w_fa_in[FA_A] = r_a_sr[0];
    w_fa_in[FA_B] = r_b_sr[0];
    w_fa_in[FA_C] = r_carry;
  end

  decoder_fa u_fa (
    .in    (w_fa_in),
    .sum   (w_fa_sum),
    .carry (w_fa_carry)
  );

  // State register; busy/done are registered decodes of the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next == RUN);
      r_done  <= (w_next == DONE);
    end
  end

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_step = 1'b0;
    w_last = (r_cnt == CNT_W'(WIDTH - 1));
    case (r_state)
      IDLE: begin
        if (start) begin
          w_load = 1'b1;
          w_next = RUN;
        end
      end
      RUN: begin
        w_step = 1'b1;
        if (w_last) w_next = DONE;
      end
      DONE: begin
        if (start) begin
          w_load = 1'b1;
          w_next = RUN;
        end else begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Operand shifters, carry, counter and result accumulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sr  <= '0;
      r_b_sr  <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else if (w_load) begin
      r_a_sr  <= a;
      r_b_sr  <= w_b_load;
      r_carry <= w_c_load;
      r_cnt   <= '0;
      r_sum   <= '0;
    end else if (w_step) begin
      r_sum   <= {w_fa_sum, r_sum[WIDTH-1:1]};
      r_a_sr  <= r_a_sr >> 1;
      r_b_sr  <= r_b_sr >> 1;
      r_carry <= w_fa_carry;
      r_cnt   <= r_cnt + CNT_W'(1);
      if (w_last) r_cout <= w_fa_carry;
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_serial_fa_ctrl.sv
// Table-driven scoreboard bench for serial_fa_ctrl (WIDTH=8).
module tb_serial_fa_ctrl;

  localparam int unsigned WIDTH = 8;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] sum;
    logic       cout;
  } vec_t;

  typedef struct {
    logic [7:0] sum;
    logic       cout;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       sub;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;

  exp_t q[$];
  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;
  int   n_done = 0;

  always #5 clk = ~clk;

  serial_fa_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_FA_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Scoreboard: every done pulse pops one expected result.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      exp_t e;
      n_done++;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 required=0");
      end else begin
        e = q.pop_front();
        chk("sum", 32'(sum), 32'(e.sum));
        chk("cout", 32'(cout), 32'(e.cout));
      end
    end
  end

  task automatic issue(input vec_t v);
    exp_t e;
    @(negedge clk);
    a = v.a; b = v.b; cin = v.cin; sub = v.sub; start = 1'b1;
    e.sum = v.sum; e.cout = v.cout;
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits for done (bounded); exp_lat counts negedges from the current one.
  task automatic wait_done(input int exp_lat);
    int cyc = 0;
    int nb  = 0;
    while (done !== 1'b1 && cyc < 50) begin
      if (busy === 1'b1) nb++;
      @(negedge clk);
      cyc++;
    end
    if (done !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=%0d required=%0d", cyc, exp_lat);
    end else begin
      chk("latency", 32'(cyc), 32'(exp_lat));
      chk("busy_cycles", 32'(nb), 32'(exp_lat));
      chk("busy_at_done", 32'(busy), 32'd0);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] va, input logic [7:0] vb, input logic vc,
                              input logic vs, input logic [7:0] vsum, input logic vco);
    vec_t v;
    v.a = va; v.b = vb; v.cin = vc; v.sub = vs; v.sum = vsum; v.cout = vco;
    return v;
  endfunction

  initial begin
    int nd;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    rst = 1'b0;

    tbl.push_back(mk(8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0));
    tbl.push_back(mk(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1));
    tbl.push_back(mk(8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1));
    tbl.push_back(mk(8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1));
    tbl.push_back(mk(8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0));
    tbl.push_back(mk(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0));
    tbl.push_back(mk(8'hAA, 8'h55, 1'b0, 1'b0, 8'hFF, 1'b0));
`ifdef SERIAL_FA_SUB_EN
    tbl.push_back(mk(8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1));
    tbl.push_back(mk(8'h01, 8'h02, 1'b0, 1'b1, 8'hFF, 1'b0));
    tbl.push_back(mk(8'h05, 8'h05, 1'b1, 1'b1, 8'h00, 1'b1));
    tbl.push_back(mk(8'h05, 8'h05, 1'b1, 1'b0, 8'h0B, 1'b0));
`endif

    foreach (tbl[i]) begin
      issue(tbl[i]);
      chk("busy_after_start", 32'(busy), 32'd1);
      wait_done(WIDTH);
      @(negedge clk);
      chk("done_pulse_width", 32'(done), 32'd0);
      repeat (2) @(negedge clk);
      chk("hold_sum", 32'(sum), 32'(tbl[i].sum));
      chk("hold_cout", 32'(cout), 32'(tbl[i].cout));
    end

    // Restart pulse during RUN is ignored.
    nd = n_done;
    issue(mk(8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0));
    repeat (2) @(negedge clk);
    a = 8'h00; b = 8'h00; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(WIDTH - 3);
    repeat (4) @(negedge clk);
    chk("restart_ignored_done_count", 32'(n_done - nd), 32'd1);
    chk("restart_ignored_idle", 32'(busy), 32'd0);

    // Start held into DONE: second op accepted with no IDLE gap.
    issue(mk(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1));
    a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
    wait_done(WIDTH);
    begin
      exp_t e;
      e.sum = 8'h03; e.cout = 1'b0;
      q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    chk("b2b_no_gap_busy", 32'(busy), 32'd1);
    wait_done(WIDTH);
    repeat (2) @(negedge clk);

    // Reset in the 4th RUN cycle discards the operation.
    issue(mk(8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0));
    repeat (3) @(negedge clk);
    rst = 1'b1;
    q.delete();
    nd = n_done;
    @(negedge clk);
    chk("midrun_rst_busy", 32'(busy), 32'd0);
    chk("midrun_rst_sum", 32'(sum), 32'd0);
    chk("midrun_rst_cout", 32'(cout), 32'd0);
    chk("midrun_rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    repeat (WIDTH + 3) @(negedge clk);
    chk("midrun_rst_no_done", 32'(n_done - nd), 32'd0);
    issue(mk(8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0));
    wait_done(WIDTH);
    repeat (2) @(negedge clk);

    // rst and start together: rst wins.
    @(negedge clk);
    rst = 1'b1; start = 1'b1; a = 8'h11; b = 8'h22;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("rst_beats_start_busy", 32'(busy), 32'd0);
    chk("rst_beats_start_sum", 32'(sum), 32'd0);

    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
